// File: rtl/data_ram.sv
// data_ram: single-port 32-bit word RAM behind a fixed-latency request/stall
// handshake for the memory stage of a pipeline.
// Optional build macro DATA_RAM_RANGE_CHK_EN adds err_o and out-of-range
// suppression; without it, upper address bits alias onto the array.
module data_ram #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic [3:0]  mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_ready_o,
  output logic        stallreq_o
`ifdef DATA_RAM_RANGE_CHK_EN
  ,
  output logic        err_o
`endif
);

  localparam int unsigned DEPTH  = 32'(1) << DEPTH_LOG2;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     data_q;
  logic [3:0]            we_q;

  logic                  req_c;
  logic                  enter_resp_c;
  logic [ADDR_W-1:0]     acc_addr_c;
  logic [DATA_W-1:0]     acc_data_c;
  logic [3:0]            acc_we_c;
  logic [DEPTH_LOG2-1:0] acc_idx_c;
  logic                  oor_c;
  logic                  wr_en_c;
  logic [DATA_W-1:0]     rdata_d;
  logic                  unused_addr_bits;

  // A new request is only accepted in IDLE and never while reset is held
  assign req_c = rst & mem_ce_i & (state_q == ST_IDLE);

  // Operands come straight from the ports in IDLE (zero-wait case), else from the latch
  assign acc_addr_c = (state_q == ST_IDLE) ? mem_addr_i : addr_q;
  assign acc_data_c = (state_q == ST_IDLE) ? mem_data_i : data_q;
  assign acc_we_c   = (state_q == ST_IDLE) ? mem_we_i   : we_q;
  assign acc_idx_c  = acc_addr_c[DEPTH_LOG2+1:2];

`ifdef DATA_RAM_RANGE_CHK_EN
  assign oor_c = (acc_addr_c >> (DEPTH_LOG2 + 2)) != '0;
`else
  assign oor_c = 1'b0;
`endif

  // Byte offset and (when aliasing) the bits above the index carry no meaning
  assign unused_addr_bits = ^{acc_addr_c[1:0], acc_addr_c[ADDR_W-1:DEPTH_LOG2+2]};

  // Next-state, wait counter and stall request
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    stallreq_o   = 1'b0;
    enter_resp_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_c) begin
          stallreq_o = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d      = ST_RESP;
            enter_resp_c = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        stallreq_o = 1'b1;
        if (cnt_q == '0) begin
          state_d      = ST_RESP;
          enter_resp_c = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Commit/read decisions taken on the edge that enters RESP
  always_comb begin
    wr_en_c = enter_resp_c & (acc_we_c != 4'b0000) & ~oor_c;
    rdata_d = mem_data_o;
    if (enter_resp_c && (acc_we_c == 4'b0000)) begin
      rdata_d = oor_c ? '0 : mem[acc_idx_c];
    end
  end

  // Control, operand latch and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      we_q        <= '0;
      mem_ready_o <= 1'b0;
      mem_data_o  <= '0;
`ifdef DATA_RAM_RANGE_CHK_EN
      err_o       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_ready_o <= enter_resp_c;
      mem_data_o  <= rdata_d;
`ifdef DATA_RAM_RANGE_CHK_EN
      err_o       <= enter_resp_c & oor_c;
`endif
      if (req_c) begin
        addr_q <= mem_addr_i;
        data_q <= mem_data_i;
        we_q   <= mem_we_i;
      end
    end
  end

  // Storage array: byte-masked write, contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_we_c[b]) begin
          mem[acc_idx_c][8*b +: 8] <= acc_data_c[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_ram.sv
// Randomized scoreboard bench for data_ram: driver pushes expected responses,
// a monitor pops and compares on every mem_ready_o strobe.
module tb_data_ram;

  localparam int unsigned DL2 = 10;
  localparam int unsigned WC  = 1;
`ifdef DATA_RAM_RANGE_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce  = 1'b0;
  logic [3:0]  we  = 4'h0;
  logic [31:0] addr  = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        ready;
  logic        stall;
`ifdef DATA_RAM_RANGE_CHK_EN
  logic        err;
`endif

  data_ram #(.DEPTH_LOG2(DL2), .WAIT_CYCLES(WC)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_ce_i   (ce),
    .mem_we_i   (we),
    .mem_addr_i (addr),
    .mem_data_i (wdata),
    .mem_data_o (rdata),
    .mem_ready_o(ready),
    .stallreq_o (stall)
`ifdef DATA_RAM_RANGE_CHK_EN
    ,
    .err_o      (err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model [1024];
  logic [31:0] last_rd = 32'h0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every completion strobe consumes one expected response
  always @(negedge clk) begin
    exp_t e;
    if (rst && ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ready actual=1 required=0");
      end else begin
        e = exp_q.pop_front();
        chk32("rdata", rdata, e.data);
`ifdef DATA_RAM_RANGE_CHK_EN
        chk32("err", 32'(err), 32'(e.err));
`endif
      end
    end
  end

  // Issue one access, update the reference model and check the handshake timing
  task automatic access(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                        input bit perturb);
    int   idx;
    bit   oor;
    int   stalls;
    bit   done;
    exp_t e;
    oor = CHK && ((a >> (DL2 + 2)) != 32'h0);
    idx = int'(a[DL2+1:2]);
    if (w == 4'h0) begin
      e.data  = oor ? 32'h0 : model[idx];
      last_rd = e.data;
    end else begin
      if (!oor)
        for (int b = 0; b < 4; b++)
          if (w[b]) model[idx][8*b +: 8] = d[8*b +: 8];
      e.data = last_rd;
    end
    e.err = oor;
    exp_q.push_back(e);
    ce = 1'b1; we = w; addr = a; wdata = d;
    stalls = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 20 && !done; cyc++) begin
      #1;
      if (ready) begin
        done = 1'b1;
        chk32("stall_in_resp", 32'(stall), 32'h0);
      end else begin
        if (stall) stalls++;
        if (perturb && cyc > 0) begin
          ce = 1'($urandom_range(0, 1));
          we = 4'($urandom);
          addr = $urandom;
          wdata = $urandom;
        end
        @(negedge clk);
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout actual=0 required=1");
    end
    chk32("stall_cycles", 32'(stalls), 32'(WC + 1));
    ce = 1'b0; we = 4'h0;
    @(negedge clk);
    #1;
    chk32("ready_one_cycle", 32'(ready), 32'h0);
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  w;
    // reset state, request ignored while reset is held
    ce = 1'b1; we = 4'hF; addr = 32'h4; wdata = 32'h1234_5678;
    repeat (3) @(negedge clk);
    #1;
    chk32("rst_rdata", rdata, 32'h0);
    chk32("rst_ready", 32'(ready), 32'h0);
    chk32("rst_stall", 32'(stall), 32'h0);
    ce = 1'b0; we = 4'h0;
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) access(4'hF, 32'(i * 4), $urandom, 1'b0);

    // full-word write then read back
    access(4'hF, 32'h10, 32'hDEAD_BEEF, 1'b0);
    access(4'h0, 32'h10, 32'h0, 1'b0);
    chk32("deadbeef_read", rdata, 32'hDEAD_BEEF);

    // byte lane masking
    access(4'hF, 32'h20, 32'h1122_3344, 1'b0);
    access(4'h5, 32'h20, 32'hAABB_CCDD, 1'b0);
    access(4'h0, 32'h20, 32'h0, 1'b0);
    chk32("byte_lanes", rdata, 32'h11BB_33DD);

    // address above the array: aliases, or rejected with range checking
    access(4'hF, 32'h0, 32'h1234_5678, 1'b0);
    access(4'hF, 32'h1000, 32'hCAFE_F00D, 1'b0);
    access(4'h0, 32'h0, 32'h0, 1'b0);
    chk32("alias_word0", rdata, CHK ? 32'h1234_5678 : 32'hCAFE_F00D);

    // reset during the wait state of a write discards it
    access(4'hF, 32'h8, 32'h5A5A_1234, 1'b0);
    access(4'h0, 32'h10, 32'h0, 1'b0);
    ce = 1'b1; we = 4'hF; addr = 32'h8; wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    #1;
    chk32("mid_wait_stall", 32'(stall), 32'h1);
    rst = 1'b0;
    #1;
    chk32("midrst_rdata", rdata, 32'h0);
    chk32("midrst_ready", 32'(ready), 32'h0);
    chk32("midrst_stall", 32'(stall), 32'h0);
    last_rd = 32'h0;
    ce = 1'b0; we = 4'h0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    access(4'h0, 32'h8, 32'h0, 1'b0);
    chk32("reset_discard", rdata, 32'h5A5A_1234);

    // randomized traffic over a small window, with aliasing and operand churn
    for (int n = 0; n < 300; n++) begin
      w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      a = 32'($urandom_range(0, 15)) << 2;
      a = a | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_F000);
      access(w, a, $urandom, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    chk32("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
